logic_unit_pipe: RTL and testbench
==================================

// Module: logic_unit_pipe
// PURPOSE
//  Parametrised, pipelined bitwise logic unit for the ALU logic slice. Supersedes the fixed 32-bit AND-only cell.
//  Applies one of 8 bitwise ops to A/B per transaction and returns result plus zero/all-ones/parity flags.
//  Uses valid/ready handshakes on input and output and sustains 1 op/cycle under no backpressure.
// PARAMETERS
//  WIDTH   32  operand/result width in bits; legal range >= 1
//  REG_IN  1   1: input register stage present (latency 2); 0: input stage bypassed (latency 1)
// PORTS
//  clk         in   1      single clock, rising edge
//  rst_n       in   1      asynchronous, active-low reset
//  in_valid    in   1      operand transaction present
//  in_ready    out  1      unit accepts transaction this cycle
//  in_op       in   3      op select (encodings below)
//  in_a        in   WIDTH  operand A
//  in_b        in   WIDTH  operand B
//  out_valid   out  1      result transaction present
//  out_ready   in   1      downstream accepts result
//  out_result  out  WIDTH  bitwise result
//  out_zero    out  1      out_result == 0
//  out_ones    out  1      out_result == all ones
//  out_parity  out  1      XOR-reduce of out_result (1 = odd count of ones)
// BEHAVIOUR
//  - Clock/reset: one clock (clk); reset is asynchronous, active-low (rst_n).
//  - Reset (asserted anywhere, including mid-transfer): all stage valids=0, data regs=0; out_valid=0,
//    out_result=0, out_zero=0, out_ones=0, out_parity=0. In-flight ops are dropped.
//    in_ready is 1 in the first cycle after deassert.
//  - Ops: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6 ANDN (A & ~B), 7 PASSA (A). All 8 codes are defined.
//  - Handshake: a transfer occurs on a cycle with valid&&ready at the rising edge.
//    Valid must not depend on ready, on both sides.
//  - Stage S2 (output regs, always present) loads when (!s2_v || out_ready).
//  - Stage S1 (REG_IN=1) loads when (!s1_v || s2_load).
//  - in_ready: REG_IN=1 -> (!s1_v || s2_load); REG_IN=0 -> s2_load. Purely combinational from state and out_ready.
//  - Latency: input accepted at edge k -> out_valid high after edge k+2 (REG_IN=1) or k+1 (REG_IN=0).
//  - Stall: while out_valid && !out_ready, out_* hold bit-stable. S1 fills, then in_ready drops. No op lost or duplicated.
//  - Simultaneous: S2 drain and S1->S2 advance on the same edge is legal.
//    At full rate, back-to-back throughput is 1/cycle.
//  - Flags are computed from the same result registered into S2. All three update atomically with out_result.
//  - Order: results leave in acceptance order. No reordering, no bubbles inserted when not stalled.
//  - Width rules: no carries, no sign. WIDTH=1 is legal; then out_parity == out_result and out_ones == out_result.
//  - Bubbles: when no valid result advances into S2, data regs keep their old value; only s2_v clears.
// STRUCTURE
//  - Package logic_ops_pkg: localparams OP_AND..OP_PASSA (3-bit), OP_W=3.
//  - Sub-module logic_unit_core: combinational (op, a, b) -> result, zero, ones, parity; parametrised by WIDTH.
//    Instantiated once, feeding S2.
//  - Top: S1 regs generated only when REG_IN=1, S2 regs, handshake/valid logic.
// TESTING
//  1 Reset: hold rst_n=0 with in_valid=1 -> out_valid=0, out_result=0. After deassert, in_ready=1.
//  2 Ops sweep (WIDTH=32, out_ready=1): A=F0F0_00FF, B=0FF0_0F0F for ops 0..7 ->
//    AND 00F0_000F, OR FFF0_0FFF, XOR FF00_0FF0, NAND FF0F_FFF0, NOR 000F_F000,
//    XNOR 00FF_F00F, ANDN F000_00F0, PASSA F0F0_00FF. Each appears 2 cycles after acceptance.
//  3 Flags: AND of 0x1234_5678 with 0 -> zero=1, ones=0, parity=0.
//    XNOR with A=B -> ones=1, parity=0 (WIDTH even). A=0x1, B=0, OR -> parity=1.
//  4 Backpressure: stream 5 ops at 1/cycle, out_ready=0 for cycles 3..6 -> in_ready low once S1 and S2 are full.
//    out_* stable while stalled. All 5 results delivered in order, none duplicated.
//  5 Reset mid-stream: assert rst_n=0 asynchronously between edges with 2 ops in flight ->
//    out_valid falls immediately. No stale result appears after release.
//  6 REG_IN=0, WIDTH=1: A=1, B=1, ops 0..7 -> results 1,1,0,0,0,1,0,1 after 1 cycle.
//    parity == result, ones == result.

Source files
------------

// File: rtl/logic_ops_pkg.sv
// Shared op encodings for the bitwise logic slice.
package logic_ops_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_AND   = 3'd0;
  localparam logic [OP_W-1:0] OP_OR    = 3'd1;
  localparam logic [OP_W-1:0] OP_XOR   = 3'd2;
  localparam logic [OP_W-1:0] OP_NAND  = 3'd3;
  localparam logic [OP_W-1:0] OP_NOR   = 3'd4;
  localparam logic [OP_W-1:0] OP_XNOR  = 3'd5;
  localparam logic [OP_W-1:0] OP_ANDN  = 3'd6;
  localparam logic [OP_W-1:0] OP_PASSA = 3'd7;

endpackage

// File: rtl/logic_unit_core.sv
// Combinational bitwise op plus zero / all-ones / parity flags of the result.
module logic_unit_core
  import logic_ops_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [OP_W-1:0]  op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             ones_o,
  output logic             parity_o
);

  always_comb begin
    result_o = '0;
    case (op_i)
      OP_AND:   result_o = a_i & b_i;
      OP_OR:    result_o = a_i | b_i;
      OP_XOR:   result_o = a_i ^ b_i;
      OP_NAND:  result_o = ~(a_i & b_i);
      OP_NOR:   result_o = ~(a_i | b_i);
      OP_XNOR:  result_o = ~(a_i ^ b_i);
      OP_ANDN:  result_o = a_i & ~b_i;
      OP_PASSA: result_o = a_i;
      default:  result_o = '0;
    endcase
  end

  assign zero_o   = ~|result_o;
  assign ones_o   = &result_o;
  assign parity_o = ^result_o;

endmodule

// File: rtl/logic_unit_pipe.sv
// Pipelined logic unit: optional input stage S1, output stage S2, valid/ready on both sides.
module logic_unit_pipe
  import logic_ops_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter bit REG_IN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [OP_W-1:0]  in_op_i,
  input  logic [WIDTH-1:0] in_a_i,
  input  logic [WIDTH-1:0] in_b_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_result_o,
  output logic             out_zero_o,
  output logic             out_ones_o,
  output logic             out_parity_o
);

  logic             s2_load;
  logic             src_v;
  logic [OP_W-1:0]  src_op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;

  logic [WIDTH-1:0] core_res;
  logic             core_zero;
  logic             core_ones;
  logic             core_parity;

  logic             s2_v_q, s2_v_d;
  logic [WIDTH-1:0] s2_res_q, s2_res_d;
  logic             s2_zero_q, s2_zero_d;
  logic             s2_ones_q, s2_ones_d;
  logic             s2_par_q, s2_par_d;

  assign s2_load = !s2_v_q || out_ready_i;

  generate
    if (REG_IN) begin : g_s1
      logic             s1_load;
      logic             s1_v_q, s1_v_d;
      logic [OP_W-1:0]  s1_op_q, s1_op_d;
      logic [WIDTH-1:0] s1_a_q, s1_a_d;
      logic [WIDTH-1:0] s1_b_q, s1_b_d;

      assign s1_load = !s1_v_q || s2_load;

      always_comb begin
        s1_v_d  = s1_v_q;
        s1_op_d = s1_op_q;
        s1_a_d  = s1_a_q;
        s1_b_d  = s1_b_q;
        if (s1_load) begin
          s1_v_d = in_valid_i;
          if (in_valid_i) begin
            s1_op_d = in_op_i;
            s1_a_d  = in_a_i;
            s1_b_d  = in_b_i;
          end
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s1_v_q  <= 1'b0;
          s1_op_q <= '0;
          s1_a_q  <= '0;
          s1_b_q  <= '0;
        end else begin
          s1_v_q  <= s1_v_d;
          s1_op_q <= s1_op_d;
          s1_a_q  <= s1_a_d;
          s1_b_q  <= s1_b_d;
        end
      end

      assign in_ready_o = s1_load;
      assign src_v      = s1_v_q;
      assign src_op     = s1_op_q;
      assign src_a      = s1_a_q;
      assign src_b      = s1_b_q;
    end else begin : g_bypass
      assign in_ready_o = s2_load;
      assign src_v      = in_valid_i;
      assign src_op     = in_op_i;
      assign src_a      = in_a_i;
      assign src_b      = in_b_i;
    end
  endgenerate

  logic_unit_core #(.WIDTH(WIDTH)) u_core (
    .op_i    (src_op),
    .a_i     (src_a),
    .b_i     (src_b),
    .result_o(core_res),
    .zero_o  (core_zero),
    .ones_o  (core_ones),
    .parity_o(core_parity)
  );

  // Bubbles only clear the valid bit; result and flags keep their last value.
  always_comb begin
    s2_v_d    = s2_v_q;
    s2_res_d  = s2_res_q;
    s2_zero_d = s2_zero_q;
    s2_ones_d = s2_ones_q;
    s2_par_d  = s2_par_q;
    if (s2_load) begin
      s2_v_d = src_v;
      if (src_v) begin
        s2_res_d  = core_res;
        s2_zero_d = core_zero;
        s2_ones_d = core_ones;
        s2_par_d  = core_parity;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_v_q    <= 1'b0;
      s2_res_q  <= '0;
      s2_zero_q <= 1'b0;
      s2_ones_q <= 1'b0;
      s2_par_q  <= 1'b0;
    end else begin
      s2_v_q    <= s2_v_d;
      s2_res_q  <= s2_res_d;
      s2_zero_q <= s2_zero_d;
      s2_ones_q <= s2_ones_d;
      s2_par_q  <= s2_par_d;
    end
  end

  assign out_valid_o  = s2_v_q;
  assign out_result_o = s2_res_q;
  assign out_zero_o   = s2_zero_q;
  assign out_ones_o   = s2_ones_q;
  assign out_parity_o = s2_par_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Bench for logic_unit_pipe: 32-bit registered-input instance plus a 1-bit bypass instance.
module tb_logic_unit_pipe;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        inValid = 1'b0;
  logic        inReady;
  logic [2:0]  inOp = '0;
  logic [31:0] inA = '0;
  logic [31:0] inB = '0;
  logic        outValid;
  logic        outReady = 1'b1;
  logic [31:0] outResult;
  logic        outZero, outOnes, outParity;

  logic        inValid1 = 1'b0;
  logic        inReady1;
  logic [2:0]  inOp1 = '0;
  logic [0:0]  inA1 = '0;
  logic [0:0]  inB1 = '0;
  logic        outValid1;
  logic        outReady1 = 1'b1;
  logic [0:0]  outResult1;
  logic        outZero1, outOnes1, outParity1;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit latChk = 1'b0;

  txn_t        pend[$];
  logic [31:0] sb[$];
  int          accCyc[$];

  always #5 clk = ~clk;

  logic_unit_pipe #(.WIDTH(32), .REG_IN(1'b1)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (inValid),
    .in_ready_o  (inReady),
    .in_op_i     (inOp),
    .in_a_i      (inA),
    .in_b_i      (inB),
    .out_valid_o (outValid),
    .out_ready_i (outReady),
    .out_result_o(outResult),
    .out_zero_o  (outZero),
    .out_ones_o  (outOnes),
    .out_parity_o(outParity)
  );

  logic_unit_pipe #(.WIDTH(1), .REG_IN(1'b0)) dut1 (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (inValid1),
    .in_ready_o  (inReady1),
    .in_op_i     (inOp1),
    .in_a_i      (inA1),
    .in_b_i      (inB1),
    .out_valid_o (outValid1),
    .out_ready_i (outReady1),
    .out_result_o(outResult1),
    .out_zero_o  (outZero1),
    .out_ones_o  (outOnes1),
    .out_parity_o(outParity1)
  );

  // Reference behaviour straight from the op table.
  function automatic logic [31:0] refOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return a ^ b;
      3'd3:    return ~(a & b);
      3'd4:    return ~(a | b);
      3'd5:    return ~(a ^ b);
      3'd6:    return a & ~b;
      default: return a;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock step: drive at negedge, check at negedge+1, update the scoreboard at posedge.
  task automatic applyStimulus(input logic v, input logic [2:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic ordy, output logic acc);
    logic [31:0] e;
    @(negedge clk);
    inValid  = v;
    inOp     = op;
    inA      = a;
    inB      = b;
    outReady = ordy;
    #1;
    acc = inValid && inReady;
    checkOutput("in_ready", {31'd0, inReady}, {31'd0, (ordy || sb.size() < 2)});
    if (outValid) begin
      if (sb.size() == 0) begin
        checkOutput("spurious_out_valid", {31'd0, outValid}, 32'd0);
      end else begin
        e = sb[0];
        checkOutput("out_result", outResult, e);
        checkOutput("out_zero", {31'd0, outZero}, {31'd0, (e == 32'd0)});
        checkOutput("out_ones", {31'd0, outOnes}, {31'd0, (e == 32'hFFFF_FFFF)});
        checkOutput("out_parity", {31'd0, outParity}, ($countones(e) % 2 == 1) ? 32'd1 : 32'd0);
        if (latChk) checkOutput("latency", cyc - accCyc[0], 32'd2);
        if (ordy) begin
          void'(sb.pop_front());
          void'(accCyc.pop_front());
        end
      end
    end
    @(posedge clk);
    if (acc) begin
      sb.push_back(refOp(op, a, b));
      accCyc.push_back(cyc);
    end
    cyc++;
  endtask

  // Pushes everything in pend through; mode 0 full rate, 1 stall window, 2 random backpressure.
  task automatic drain(input int mode);
    int r;
    logic acc, ordy;
    txn_t t;
    r = 0;
    latChk = (mode == 0);
    while ((pend.size() > 0 || sb.size() > 0) && r < 300) begin
      case (mode)
        0:       ordy = 1'b1;
        1:       ordy = !(r >= 3 && r <= 6);
        default: ordy = ($urandom_range(0, 9) < 7);
      endcase
      if (pend.size() > 0) begin
        t = pend[0];
        applyStimulus(1'b1, t.op, t.a, t.b, ordy, acc);
        if (acc) void'(pend.pop_front());
      end else begin
        applyStimulus(1'b0, 3'd0, 32'd0, 32'd0, ordy, acc);
      end
      r++;
    end
    latChk = 1'b0;
    checkOutput("drained_pending", pend.size(), 32'd0);
    checkOutput("drained_scoreboard", sb.size(), 32'd0);
  endtask

  initial begin
    logic acc;
    txn_t t;
    logic exp1 [8];
    logic [31:0] rv;
    exp1 = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    // Reset held with a transaction offered.
    rst_n    = 1'b0;
    inValid  = 1'b1;
    inOp     = 3'd1;
    inA      = 32'hDEAD_BEEF;
    inB      = 32'h1234_5678;
    inValid1 = 1'b1;
    inOp1    = 3'd1;
    inA1     = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("rst_out_valid", {31'd0, outValid}, 32'd0);
    checkOutput("rst_out_result", outResult, 32'd0);
    checkOutput("rst_out_zero", {31'd0, outZero}, 32'd0);
    checkOutput("rst_out_ones", {31'd0, outOnes}, 32'd0);
    checkOutput("rst_out_parity", {31'd0, outParity}, 32'd0);
    checkOutput("rst_out_valid_w1", {31'd0, outValid1}, 32'd0);
    inValid  = 1'b0;
    inValid1 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("post_rst_in_ready", {31'd0, inReady}, 32'd1);
    checkOutput("post_rst_in_ready_w1", {31'd0, inReady1}, 32'd1);

    $display("[TB] ops sweep");
    for (int i = 0; i < 8; i++) begin
      t.op = 3'(i);
      t.a  = 32'hF0F0_00FF;
      t.b  = 32'h0FF0_0F0F;
      pend.push_back(t);
    end
    drain(0);

    $display("[TB] flags");
    t.op = 3'd0; t.a = 32'h1234_5678; t.b = 32'h0; pend.push_back(t);
    rv = $urandom();
    t.op = 3'd5; t.a = rv; t.b = rv; pend.push_back(t);
    t.op = 3'd1; t.a = 32'h1; t.b = 32'h0; pend.push_back(t);
    drain(0);

    $display("[TB] backpressure");
    for (int i = 0; i < 5; i++) begin
      t.op = 3'($urandom_range(0, 7));
      t.a  = $urandom();
      t.b  = $urandom();
      pend.push_back(t);
    end
    drain(1);

    $display("[TB] random stream");
    for (int i = 0; i < 40; i++) begin
      t.op = 3'($urandom_range(0, 7));
      t.a  = $urandom();
      t.b  = $urandom();
      pend.push_back(t);
    end
    drain(2);

    $display("[TB] reset mid-stream");
    applyStimulus(1'b1, 3'd2, 32'hAAAA_5555, 32'h0F0F_0F0F, 1'b1, acc);
    applyStimulus(1'b1, 3'd6, 32'hFFFF_0000, 32'h00FF_00FF, 1'b1, acc);
    inValid = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_out_valid", {31'd0, outValid}, 32'd0);
    checkOutput("midrst_out_result", outResult, 32'd0);
    sb.delete();
    accCyc.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) applyStimulus(1'b0, 3'd0, 32'd0, 32'd0, 1'b1, acc);

    $display("[TB] width 1 bypass");
    for (int i = 0; i <= 8; i++) begin
      @(negedge clk);
      if (i < 8) begin
        inValid1 = 1'b1;
        inOp1    = 3'(i);
        inA1     = 1'b1;
        inB1     = 1'b1;
      end else begin
        inValid1 = 1'b0;
      end
      #1;
      if (i < 8) checkOutput("w1_in_ready", {31'd0, inReady1}, 32'd1);
      if (i > 0) begin
        checkOutput("w1_out_valid", {31'd0, outValid1}, 32'd1);
        checkOutput("w1_result", {31'd0, outResult1}, {31'd0, exp1[i-1]});
        checkOutput("w1_ones", {31'd0, outOnes1}, {31'd0, exp1[i-1]});
        checkOutput("w1_parity", {31'd0, outParity1}, {31'd0, exp1[i-1]});
        checkOutput("w1_zero", {31'd0, outZero1}, {31'd0, !exp1[i-1]});
      end
      @(posedge clk);
    end
    @(negedge clk);
    #1;
    checkOutput("w1_idle_out_valid", {31'd0, outValid1}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
